// File: rtl/instr_encoder.sv
// instr_encoder: packs decoded RV32I fields back into 32-bit instruction words,
// buffers them in a small FIFO and streams them out as sequential
// word-addressed writes into instruction memory.
module instr_encoder #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
   parameter int unsigned ADDR_W     = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_last,
   input  logic [2:0]        in_fmt,
   input  logic [6:0]        in_opcode,
   input  logic [2:0]        in_funct3,
   input  logic [6:0]        in_funct7,
   input  logic [4:0]        in_rd,
   input  logic [4:0]        in_rs1,
   input  logic [4:0]        in_rs2,
   input  logic [31:0]       in_imm,
   output logic              wr_valid,
   input  logic              wr_ready,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [15:0]       count
);

   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LOAD,
      S_DRAIN,
      S_DONE
   } state_e;

   typedef enum logic [2:0] {
      FMT_R = 3'd0,
      FMT_I = 3'd1,
      FMT_S = 3'd2,
      FMT_B = 3'd3,
      FMT_U = 3'd4,
      FMT_J = 3'd5
   } fmt_e;

   state_e              state_q, state_d;
   logic [31:0]         enc_word;
   logic                enc_ok;
   logic                accept, push, pop, start_ok;

   logic [31:0]         mem_q [FIFO_DEPTH];
   logic [PTR_W:0]      wr_ptr_q, rd_ptr_q;
   logic                fifo_empty, fifo_full;

   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [15:0]         count_q, count_d;
   logic                err_q, err_d;

   // Combinational field packing; illegal formats and odd B/J offsets are flagged.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      enc_word = '0;
      enc_ok   = 1'b1;
      case (in_fmt)
         FMT_R: enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
         FMT_I: enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
         FMT_S: enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
         FMT_B: begin
            enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                        in_imm[4:1], in_imm[11], in_opcode};
            enc_ok   = ~in_imm[0];
         end
         FMT_U: enc_word = {in_imm[31:12], in_rd, in_opcode};
         FMT_J: begin
            enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
            enc_ok   = ~in_imm[0];
         end
         default: enc_ok = 1'b0;
      endcase
   end

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                       (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);

   assign accept   = in_valid & in_ready;
   assign push     = accept & enc_ok;
   assign pop      = wr_valid & wr_ready;
   assign start_ok = start & (state_q == S_IDLE);

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // FSM next-state logic; start outside IDLE is ignored.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (start)              state_d = S_LOAD;
         S_LOAD:  if (accept && in_last)  state_d = S_DRAIN;
         S_DRAIN: if (fifo_empty)         state_d = S_DONE;
         S_DONE:                          state_d = S_IDLE;
         default:                         state_d = S_IDLE;
      endcase
   end

   // FSM outputs; a full FIFO still accepts when a pop frees a slot on the same edge.
   always_comb begin
      in_ready = (state_q == S_LOAD) && (!fifo_full || wr_ready);
      busy     = (state_q != S_IDLE);
      done     = (state_q == S_DONE);
   end

   // FIFO pointers; reset empties the buffer and discards any queued words.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   // FIFO storage.
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; the pointers alone define which entries are valid.
      if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= enc_word;
   end

   // Session bookkeeping: address, written-word count and sticky error.
   always_comb begin
      addr_d  = addr_q;
      count_d = count_q;
      err_d   = err_q;
      if (start_ok) begin
         addr_d  = ADDR_W'(BASE_ADDR);
         count_d = '0;
         err_d   = 1'b0;
      end else begin
         if (pop) begin
            addr_d = addr_q + ADDR_W'(4);
            if (count_q != 16'hFFFF) count_d = count_q + 16'd1;
         end
         if (accept && !enc_ok) err_d = 1'b1;
      end
   end

   // Session bookkeeping registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= ADDR_W'(BASE_ADDR);
         count_q <= '0;
         err_q   <= 1'b0;
      end else begin
         addr_q  <= addr_d;
         count_q <= count_d;
         err_q   <= err_d;
      end
   end

   // Head of the FIFO drives the write port directly, so data and address
   // stay put for as long as the memory stalls.
   assign wr_valid = !fifo_empty;
   assign wr_data  = fifo_empty ? 32'h0 : mem_q[rd_ptr_q[PTR_W-1:0]];
   assign wr_addr  = addr_q;
   assign count    = count_q;
   assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// bundles scored against an arithmetic encoding model and an in-order queue.
module tb_instr_encoder;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk, rst_n, start;
   logic        in_valid, in_ready, in_last;
   logic [2:0]  in_fmt, in_funct3;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [31:0] in_imm;
   logic        wr_valid, wr_ready;
   logic [31:0] wr_addr, wr_data;
   logic        busy, done, err;
   logic [15:0] count;

   int tests_run = 0;
   int tests_failed = 0;

   logic [31:0] exp_q[$];
   logic [31:0] obs_data_q[$];
   logic [31:0] obs_addr_q[$];
   bit          exp_err;
   bit          mon_en;
   bit          rnd_stop;
   logic [31:0] mw;
   bit          mok;

   instr_encoder #(.FIFO_DEPTH(4), .BASE_ADDR(BASE), .ADDR_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err), .count(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference encoding: place each field at its bit weight with plain arithmetic.
   function automatic bit model_encode(input logic [2:0] fmt, input logic [6:0] opc,
                                       input logic [2:0] fn3, input logic [6:0] fn7,
                                       input logic [4:0] rdi, input logic [4:0] rs1i,
                                       input logic [4:0] rs2i, input logic [31:0] imm,
                                       output logic [31:0] w);
      logic [31:0] op, f3, f7, rd, r1, r2;
      bit ok;
      op = 32'(opc); f3 = 32'(fn3); f7 = 32'(fn7);
      rd = 32'(rdi); r1 = 32'(rs1i); r2 = 32'(rs2i);
      ok = 1'b1;
      case (fmt)
         3'd0: w = op + (rd << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20) + (f7 << 25);
         3'd1: w = op + (rd << 7) + (f3 << 12) + (r1 << 15) + ((imm % 4096) << 20);
         3'd2: w = op + ((imm % 32) << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20)
                   + (((imm / 32) % 128) << 25);
         3'd3: begin
            ok = (imm % 2 == 0);
            w  = op + (((imm / 2048) % 2) << 7) + (((imm / 2) % 16) << 8) + (f3 << 12)
                 + (r1 << 15) + (r2 << 20) + (((imm / 32) % 64) << 25)
                 + (((imm / 4096) % 2) << 31);
         end
         3'd4: w = op + (rd << 7) + (imm / 4096) * 4096;
         3'd5: begin
            ok = (imm % 2 == 0);
            w  = op + (rd << 7) + (((imm / 4096) % 256) << 12) + (((imm / 2048) % 2) << 20)
                 + (((imm / 2) % 1024) << 21) + (((imm / 1048576) % 2) << 31);
         end
         default: begin
            ok = 1'b0;
            w  = 32'h0;
         end
      endcase
      return ok;
   endfunction

   // Observe handshakes half a cycle before the edge that completes them.
   always @(negedge clk) begin
      if (rst_n && mon_en) begin
         if (in_valid && in_ready) begin
            mok = model_encode(in_fmt, in_opcode, in_funct3, in_funct7,
                               in_rd, in_rs1, in_rs2, in_imm, mw);
            if (mok) exp_q.push_back(mw);
            else     exp_err = 1'b1;
         end
         if (wr_valid && wr_ready) begin
            obs_data_q.push_back(wr_data);
            obs_addr_q.push_back(wr_addr);
         end
      end
   end

   task automatic clear_model();
      exp_q.delete();
      obs_data_q.delete();
      obs_addr_q.delete();
      exp_err = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Hold in_valid with the current fields until accepted (bounded).
   task automatic send_cur();
      bit acc = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         if (in_ready) acc = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      tests_run++;
      if (!acc) begin
         tests_failed++;
         $display("FAIL send_timeout: in_ready got 0 for 200 cycles, want 1 (fmt %0d)", in_fmt);
      end
   endtask

   task automatic send(input logic [2:0] fmt, input logic [6:0] opc, input logic [2:0] fn3,
                       input logic [6:0] fn7, input logic [4:0] rdi, input logic [4:0] rs1i,
                       input logic [4:0] rs2i, input logic [31:0] imm, input bit last);
      in_fmt = fmt; in_opcode = opc; in_funct3 = fn3; in_funct7 = fn7;
      in_rd = rdi; in_rs1 = rs1i; in_rs2 = rs2i; in_imm = imm; in_last = last;
      send_cur();
   endtask

   task automatic drive_rand(input bit last, input bit allow_bad);
      logic [2:0] f;
      f = 3'($urandom_range(0, 5));
      if (allow_bad && $urandom_range(0, 7) == 0) f = 3'($urandom_range(6, 7));
      in_fmt = f;
      in_opcode = 7'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
      in_rd = 5'($urandom); in_rs1 = 5'($urandom); in_rs2 = 5'($urandom);
      in_imm = $urandom;
      if ((f == 3'd3 || f == 3'd5) && !(allow_bad && $urandom_range(0, 7) == 0))
         in_imm[0] = 1'b0;
      in_last = last;
   endtask

   task automatic send_rand(input bit last, input bit allow_bad);
      drive_rand(last, allow_bad);
      send_cur();
   endtask

   // Wait (bounded) for done; report whether it lasted exactly one cycle.
   task automatic wait_done(output bit seen, output bit one_cycle);
      seen = 1'b0;
      one_cycle = 1'b0;
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      if (seen) begin
         @(negedge clk);
         one_cycle = !done;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b0;
      in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
      in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
      mon_en = 1'b0; rnd_stop = 1'b0;
      clear_model();
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      tests_run++;
      if ({in_ready, wr_valid, busy, done, err} !== 5'b0) begin
         tests_failed++;
         $display("FAIL reset_flags: {in_ready,wr_valid,busy,done,err} got %b want 00000",
                  {in_ready, wr_valid, busy, done, err});
      end
      tests_run++;
      if (wr_addr !== BASE) begin
         tests_failed++; $display("FAIL reset_addr: got %h want %h", wr_addr, BASE);
      end
      tests_run++;
      if (wr_data !== 32'h0 || count !== 16'h0) begin
         tests_failed++;
         $display("FAIL reset_data_count: wr_data %h count %0d, want 0 and 0", wr_data, count);
      end
   endtask

   task automatic test_single();
      bit seen, one;
      clear_model(); mon_en = 1'b1; wr_ready = 1'b1;
      pulse_start();
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      tests_run++;
      if (wr_valid !== 1'b1 || wr_data !== 32'h0050_0093 || wr_addr !== BASE) begin
         tests_failed++;
         $display("FAIL single_latency: valid %b data %h addr %h, want 1 00500093 %h",
                  wr_valid, wr_data, wr_addr, BASE);
      end
      wait_done(seen, one);
      tests_run++;
      if ({seen, one} !== 2'b11) begin
         tests_failed++; $display("FAIL single_done: seen %b one_cycle %b, want 1 1", seen, one);
      end
      tests_run++;
      if (count !== 16'd1 || busy !== 1'b0) begin
         tests_failed++; $display("FAIL single_end: count %0d busy %b, want 1 0", count, busy);
      end
   endtask

   task automatic test_formats();
      bit seen, one;
      logic [31:0] want [5];
      want[0] = 32'h0020_81B3; want[1] = 32'h0020_A423; want[2] = 32'hFE20_8EE3;
      want[3] = 32'h1234_52B7; want[4] = 32'h0080_006F;
      clear_model(); mon_en = 1'b1; wr_ready = 1'b1;
      pulse_start();
      send(3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
      send(3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
      send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b0);
      send(3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b0);
      send(3'd5, 7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd8, 1'b1);
      wait_done(seen, one);
      tests_run++;
      if (obs_data_q.size() != 5 || !seen) begin
         tests_failed++;
         $display("FAIL formats_count: writes %0d done %b, want 5 1", obs_data_q.size(), seen);
      end
      for (int i = 0; i < 5 && i < obs_data_q.size(); i++) begin
         tests_run++;
         if (obs_data_q[i] !== want[i] || obs_addr_q[i] !== BASE + 32'(4 * i)) begin
            tests_failed++;
            $display("FAIL formats_word%0d: data %h addr %h, want %h %h",
                     i, obs_data_q[i], obs_addr_q[i], want[i], BASE + 32'(4 * i));
         end
      end
   endtask

   task automatic test_random();
      bit seen, one;
      clear_model(); mon_en = 1'b1; rnd_stop = 1'b0; wr_ready = 1'b1;
      pulse_start();
      fork
         begin
            for (int i = 0; i < 24; i++) send_rand(i == 23, 1'b1);
            rnd_stop = 1'b1;
         end
         begin
            while (!rnd_stop) begin
               @(posedge clk); #1;
               wr_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      wr_ready = 1'b1;
      wait_done(seen, one);
      tests_run++;
      if (obs_data_q.size() != exp_q.size() || !seen) begin
         tests_failed++;
         $display("FAIL random_count: writes %0d done %b, want %0d 1",
                  obs_data_q.size(), seen, exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
         tests_run++;
         if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== BASE + 32'(4 * i)) begin
            tests_failed++;
            $display("FAIL random_word%0d: data %h addr %h, want %h %h",
                     i, obs_data_q[i], obs_addr_q[i], exp_q[i], BASE + 32'(4 * i));
         end
      end
      tests_run++;
      if (count !== 16'(exp_q.size()) || err !== exp_err) begin
         tests_failed++;
         $display("FAIL random_status: count %0d err %b, want %0d %b",
                  count, err, exp_q.size(), exp_err);
      end
   endtask

   task automatic test_back_to_back();
      bit seen, one;
      logic [31:0] held;
      clear_model(); mon_en = 1'b1; wr_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 4; i++) send_rand(1'b0, 1'b0);
      fork
         begin
            send_rand(1'b0, 1'b0);
            send_rand(1'b1, 1'b0);
         end
         begin
            @(negedge clk);
            held = wr_data;
            repeat (3) @(negedge clk);
            tests_run++;
            if (in_ready !== 1'b0 || exp_q.size() != 4) begin
               tests_failed++;
               $display("FAIL bp_full: in_ready %b accepts %0d, want 0 4", in_ready, exp_q.size());
            end
            tests_run++;
            if (wr_valid !== 1'b1 || wr_data !== held || wr_data !== exp_q[0] || wr_addr !== BASE) begin
               tests_failed++;
               $display("FAIL bp_stable: valid %b data %h addr %h, want 1 %h %h",
                        wr_valid, wr_data, wr_addr, exp_q[0], BASE);
            end
            @(posedge clk); #1;
            wr_ready = 1'b1;
         end
      join
      wait_done(seen, one);
      tests_run++;
      if (obs_data_q.size() != 6 || exp_q.size() != 6 || count !== 16'd6 || !seen) begin
         tests_failed++;
         $display("FAIL bp_count: writes %0d accepts %0d count %0d done %b, want 6 6 6 1",
                  obs_data_q.size(), exp_q.size(), count, seen);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
         tests_run++;
         if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== BASE + 32'(4 * i)) begin
            tests_failed++;
            $display("FAIL bp_word%0d: data %h addr %h, want %h %h",
                     i, obs_data_q[i], obs_addr_q[i], exp_q[i], BASE + 32'(4 * i));
         end
      end
   endtask

   task automatic test_errors();
      bit seen, one;
      clear_model(); mon_en = 1'b1; wr_ready = 1'b1;
      pulse_start();
      send(3'd7, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd1, 1'b0);
      tests_run++;
      if (err !== 1'b1) begin
         tests_failed++; $display("FAIL err_fmt: err got %b want 1", err);
      end
      send(3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd2, 5'd0, 5'd0, 32'd7, 1'b1);
      wait_done(seen, one);
      tests_run++;
      if (!seen || obs_data_q.size() != 1 || count !== 16'd1 || err !== 1'b1) begin
         tests_failed++;
         $display("FAIL err_session: done %b writes %0d count %0d err %b, want 1 1 1 1",
                  seen, obs_data_q.size(), count, err);
      end
      tests_run++;
      if (obs_data_q.size() > 0 && (obs_data_q[0] !== 32'h0070_0113 || obs_addr_q[0] !== BASE)) begin
         tests_failed++;
         $display("FAIL err_word: data %h addr %h, want 00700113 %h", obs_data_q[0], obs_addr_q[0], BASE);
      end
   endtask

   task automatic test_start_and_reset();
      bit seen, one;
      clear_model(); mon_en = 1'b1; wr_ready = 1'b1;
      pulse_start();
      tests_run++;
      if (err !== 1'b0) begin
         tests_failed++; $display("FAIL start_clears_err: err got %b want 0", err);
      end
      send_rand(1'b0, 1'b0);
      repeat (3) @(posedge clk); #1;
      wr_ready = 1'b0;
      pulse_start();
      tests_run++;
      if (count !== 16'd1 || wr_addr !== BASE + 32'd4 || busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL start_ignored: count %0d addr %h busy %b, want 1 %h 1",
                  count, wr_addr, busy, BASE + 32'd4);
      end
      for (int i = 0; i < 3; i++) send_rand(1'b0, 1'b0);
      tests_run++;
      if (wr_valid !== 1'b1) begin
         tests_failed++; $display("FAIL pre_reset_valid: wr_valid got %b want 1", wr_valid);
      end
      #2 rst_n = 1'b0;
      #1;
      tests_run++;
      if ({in_ready, wr_valid, busy, done, err} !== 5'b0 || wr_addr !== BASE ||
          wr_data !== 32'h0 || count !== 16'h0) begin
         tests_failed++;
         $display("FAIL async_reset: flags %b addr %h data %h count %0d, want 00000 %h 0 0",
                  {in_ready, wr_valid, busy, done, err}, wr_addr, wr_data, count, BASE);
      end
      clear_model();
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      wr_ready = 1'b1;
      pulse_start();
      send(3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1);
      tests_run++;
      if (wr_valid !== 1'b1 || wr_addr !== BASE || wr_data !== 32'h0050_0093) begin
         tests_failed++;
         $display("FAIL restart: valid %b addr %h data %h, want 1 %h 00500093",
                  wr_valid, wr_addr, wr_data, BASE);
      end
      wait_done(seen, one);
      tests_run++;
      if (!seen || count !== 16'd1) begin
         tests_failed++; $display("FAIL restart_done: done %b count %0d, want 1 1", seen, count);
      end
   endtask

   task automatic test_push_pop();
      bit seen, one;
      clear_model(); mon_en = 1'b1; wr_ready = 1'b0;
      pulse_start();
      for (int i = 0; i < 4; i++) send_rand(1'b0, 1'b0);
      drive_rand(1'b0, 1'b0);
      in_valid = 1'b1; wr_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b1 || wr_valid !== 1'b1) begin
         tests_failed++;
         $display("FAIL pp_both: in_ready %b wr_valid %b, want 1 1", in_ready, wr_valid);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; wr_ready = 1'b0;
      @(negedge clk);
      tests_run++;
      if (in_ready !== 1'b0 || obs_data_q.size() != 1 || exp_q.size() != 5) begin
         tests_failed++;
         $display("FAIL pp_occupancy: in_ready %b writes %0d accepts %0d, want 0 1 5",
                  in_ready, obs_data_q.size(), exp_q.size());
      end
      @(posedge clk); #1;
      wr_ready = 1'b1;
      send_rand(1'b1, 1'b0);
      wait_done(seen, one);
      tests_run++;
      if (!seen || obs_data_q.size() != 6 || count !== 16'd6) begin
         tests_failed++;
         $display("FAIL pp_count: done %b writes %0d count %0d, want 1 6 6",
                  seen, obs_data_q.size(), count);
      end
      for (int i = 0; i < exp_q.size() && i < obs_data_q.size(); i++) begin
         tests_run++;
         if (obs_data_q[i] !== exp_q[i] || obs_addr_q[i] !== BASE + 32'(4 * i)) begin
            tests_failed++;
            $display("FAIL pp_word%0d: data %h addr %h, want %h %h",
                     i, obs_data_q[i], obs_addr_q[i], exp_q[i], BASE + 32'(4 * i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_formats();
      test_random();
      test_back_to_back();
      test_errors();
      test_start_and_reset();
      test_push_pop();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached before the summary");
      $fatal(1);
   end

endmodule
